ifft8_stream: RTL and testbench
===============================

Name: ifft8_stream

Overview:
- 8-point radix-2 DIT inverse FFT in Q8.8 fixed point; converts the frequency-domain bins produced by the team's 8-point forward FFT back to time-domain samples.
- Samples stream in one complex value per cycle over a valid/ready handshake and stream out the same way.
- Frame flow: buffer 8 bins, run 5 compute cycles, emit 8 samples scaled by 1/8.
- Sits downstream of spectral processing, feeding the time-domain sink.

Parameters:
- DATA_W, 16, width of each real/imag I/O sample (signed two's complement, Q8.8).
- TW_COEF, 181, unsigned 1/sqrt(2) twiddle constant in Q0.8 (0xB5).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- in_valid  in  1  input bin valid.
- in_ready  out  1  block can accept a bin.
- in_real  in  DATA_W  real part of bin X[k], k in natural order 0..7.
- in_imag  in  DATA_W  imag part of bin X[k].
- out_valid  out  1  output sample valid.
- out_ready  in  1  sink accepts sample.
- out_real  out  DATA_W  real part of x[n].
- out_imag  out  DATA_W  imag part of x[n].
- out_index  out  3  n of the sample currently presented.
- out_last  out  1  high with n=7.
- busy  out  1  high in any state other than LOAD.

Behaviour:
- Reset (async, any state): state=LOAD, in/out counters=0, in_ready=1, out_valid=0, out_last=0, out_index=0, out_real/imag=0, busy=0. Internal buffers are not required to clear. A reset mid-frame discards that frame.
- FSM: LOAD -> ST1 -> ST2 -> ST3 -> ST4 -> ST5 -> OUT -> LOAD.
- LOAD: in_ready=1. Each cycle with in_valid&in_ready writes X[in_cnt] and increments in_cnt. When sample 7 is accepted, go to ST1 and in_ready=0. in_valid gaps are allowed.
- Internal width: 19-bit signed (DATA_W+3). Inputs are sign-extended. All adds and subtracts are exact at 19 bits.
- ST1 (bit-reversed pairs):
  - g0=X0+X4, g1=X0-X4
  - g2=X2+X6, g3=X2-X6
  - g4=X1+X5, g5=X1-X5
  - g6=X3+X7, g7=X3-X7
- ST2 (W4^-1 = +j):
  - h0=g0+g2, h2=g0-g2
  - h1=(g1r-g3i, g1i+g3r), h3=(g1r+g3i, g1i-g3r)
  - h4..h7: same pattern on g4..g7.
- ST3 temps:
  - t0=h5r-h5i, t1=h5r+h5i
  - t2=-h7r-h7i, t3=h7r-h7i
- ST4:
  - p5=(t0*TW_COEF>>>8, t1*TW_COEF>>>8), p7=(t2*TW_COEF>>>8, t3*TW_COEF>>>8).
  - Products are full-width signed; >>> is an arithmetic (floor) shift; results are truncated to 19 bits.
- ST5 (results stored as x>>>3, floor, low DATA_W bits):
  - x0=h0+h4, x4=h0-h4
  - x1=h1+p5, x5=h1-p5
  - x2=(h2r-h6i, h2i+h6r), x6=(h2r+h6i, h2i-h6r)
  - x3=h3+p7, x7=h3-p7
- Latency: out_valid rises exactly 5 edges after the edge accepting sample 7.
- OUT:
  - out_valid=1; out data = x[out_index]; out_last=(out_index==7).
  - On out_valid&out_ready, out_index increments.
  - On the transfer with out_last, go to LOAD with out_valid=0, out_index=0, in_ready=1 next cycle.
  - While out_ready=0, all outputs hold stable.
- in_ready=0 in ST1..OUT. in_valid is ignored there; no bins are lost or overwritten.
- Back-to-back frames: a new bin can be accepted on the cycle after the last output transfer.

Test Plan:
- Impulse: X0=(2048,0), X1..7=0 -> all 8 outputs (256,0), out_valid 5 edges after last input, out_last only at n=7.
- Tone: X1=(2048,0), rest 0 -> x0..x7 = (256,0),(181,181),(0,256),(-181,181),(-256,0),(-181,-181),(0,-256),(181,-181).
- Floor rounding: X0=(-1,0), rest 0 -> all outputs (-1,0). X0=(7,0) -> all outputs (0,0).
- Backpressure: tone frame with out_ready low for 3 cycles at n=2 -> out_index=2 and data held stable. Sequence completes unchanged. in_ready stays 0 until after the n=7 transfer.
- Input gaps / ignore: in_valid toggled 1,0,1 across 8 bins -> correct impulse result. in_valid=1 during ST1..OUT with other data -> results unaffected.
- Reset mid-operation: assert RST asynchronously in ST3 -> outputs zero and in_ready=1 immediately. A fresh impulse frame then yields all (256,0).

Source files
------------

// File: rtl/ifft8_stream.sv
// Streaming 8-point radix-2 DIT inverse FFT, Q8.8 I/O, 19-bit internal datapath.
// Buffers 8 bins, runs 5 in-place compute steps, then emits 8 samples scaled by 1/8.
module ifft8_stream #(
    parameter int DATA_W  = 16,
    parameter int TW_COEF = 181
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic [2:0]        out_index,
    output logic              out_last,
    output logic              busy
);
    localparam int IW = DATA_W + 3;
    localparam int PW = IW + 10;
    localparam logic signed [9:0] TW = 10'(TW_COEF);

    typedef enum logic [2:0] {LOAD, ST1, ST2, ST3, ST4, ST5, OUT} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        in_cnt_reg, in_cnt_next;
    logic [2:0]        out_idx_reg, out_idx_next, nxt_idx;
    logic [DATA_W-1:0] out_re_reg, out_re_next, out_im_reg, out_im_next;

    // One working array reused by every stage; each step overwrites it in place.
    logic signed [IW-1:0] ar_reg [8];
    logic signed [IW-1:0] ai_reg [8];
    logic signed [IW-1:0] ar_next [8];
    logic signed [IW-1:0] ai_next [8];

    logic signed [IW-1:0] g_r [8];
    logic signed [IW-1:0] g_i [8];
    logic signed [IW-1:0] h_r [8];
    logic signed [IW-1:0] h_i [8];
    logic signed [IW-1:0] x_r [8];
    logic signed [IW-1:0] x_i [8];
    logic signed [PW-1:0] prod [4];

    // Stage 1: pair bins in bit-reversed order (0,4) (2,6) (1,5) (3,7).
    for (genvar gi = 0; gi < 4; gi++) begin : g_st1
        localparam int LO = 2 * (gi % 2) + gi / 2;
        assign g_r[2*gi]   = ar_reg[LO] + ar_reg[LO+4];
        assign g_i[2*gi]   = ai_reg[LO] + ai_reg[LO+4];
        assign g_r[2*gi+1] = ar_reg[LO] - ar_reg[LO+4];
        assign g_i[2*gi+1] = ai_reg[LO] - ai_reg[LO+4];
    end

    // Stage 2: 4-point butterflies, odd leg rotated by +j.
    for (genvar gi = 0; gi < 2; gi++) begin : g_st2
        localparam int B = 4 * gi;
        assign h_r[B]   = ar_reg[B] + ar_reg[B+2];
        assign h_i[B]   = ai_reg[B] + ai_reg[B+2];
        assign h_r[B+2] = ar_reg[B] - ar_reg[B+2];
        assign h_i[B+2] = ai_reg[B] - ai_reg[B+2];
        assign h_r[B+1] = ar_reg[B+1] - ai_reg[B+3];
        assign h_i[B+1] = ai_reg[B+1] + ar_reg[B+3];
        assign h_r[B+3] = ar_reg[B+1] + ai_reg[B+3];
        assign h_i[B+3] = ai_reg[B+1] - ar_reg[B+3];
    end

    // Stage 4 twiddle products on the temporaries parked in slots 5 and 7.
    assign prod[0] = PW'(ar_reg[5]) * PW'(TW);
    assign prod[1] = PW'(ai_reg[5]) * PW'(TW);
    assign prod[2] = PW'(ar_reg[7]) * PW'(TW);
    assign prod[3] = PW'(ai_reg[7]) * PW'(TW);

    // Stage 5: final butterflies; pair (2,6) takes the +j rotation.
    for (genvar gi = 0; gi < 4; gi++) begin : g_st5
        if (gi == 2) begin : g_rot
            assign x_r[gi]   = ar_reg[gi] - ai_reg[gi+4];
            assign x_i[gi]   = ai_reg[gi] + ar_reg[gi+4];
            assign x_r[gi+4] = ar_reg[gi] + ai_reg[gi+4];
            assign x_i[gi+4] = ai_reg[gi] - ar_reg[gi+4];
        end else begin : g_plain
            assign x_r[gi]   = ar_reg[gi] + ar_reg[gi+4];
            assign x_i[gi]   = ai_reg[gi] + ai_reg[gi+4];
            assign x_r[gi+4] = ar_reg[gi] - ar_reg[gi+4];
            assign x_i[gi+4] = ai_reg[gi] - ai_reg[gi+4];
        end
    end

    assign nxt_idx = out_idx_reg + 3'd1;

    always_comb begin
        state_next   = state_reg;
        in_cnt_next  = in_cnt_reg;
        out_idx_next = out_idx_reg;
        out_re_next  = out_re_reg;
        out_im_next  = out_im_reg;
        ar_next      = ar_reg;
        ai_next      = ai_reg;
        case (state_reg)
            LOAD: begin
                if (in_valid) begin
                    ar_next[in_cnt_reg] = IW'($signed(in_real));
                    ai_next[in_cnt_reg] = IW'($signed(in_imag));
                    in_cnt_next = in_cnt_reg + 3'd1;
                    if (in_cnt_reg == 3'd7) state_next = ST1;
                end
            end
            ST1: begin
                ar_next    = g_r;
                ai_next    = g_i;
                state_next = ST2;
            end
            ST2: begin
                ar_next    = h_r;
                ai_next    = h_i;
                state_next = ST3;
            end
            ST3: begin
                ar_next[5] = ar_reg[5] - ai_reg[5];
                ai_next[5] = ar_reg[5] + ai_reg[5];
                ar_next[7] = -ar_reg[7] - ai_reg[7];
                ai_next[7] = ar_reg[7] - ai_reg[7];
                state_next = ST4;
            end
            ST4: begin
                ar_next[5] = IW'(prod[0] >>> 8);
                ai_next[5] = IW'(prod[1] >>> 8);
                ar_next[7] = IW'(prod[2] >>> 8);
                ai_next[7] = IW'(prod[3] >>> 8);
                state_next = ST5;
            end
            ST5: begin
                for (int k = 0; k < 8; k++) begin
                    ar_next[k] = x_r[k] >>> 3;
                    ai_next[k] = x_i[k] >>> 3;
                end
                out_re_next = DATA_W'(x_r[0] >>> 3);
                out_im_next = DATA_W'(x_i[0] >>> 3);
                state_next  = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_idx_next = nxt_idx;
                    out_re_next  = ar_reg[nxt_idx][DATA_W-1:0];
                    out_im_next  = ai_reg[nxt_idx][DATA_W-1:0];
                    if (out_idx_reg == 3'd7) state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= LOAD;
            in_cnt_reg  <= 3'd0;
            out_idx_reg <= 3'd0;
            out_re_reg  <= '0;
            out_im_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            in_cnt_reg  <= in_cnt_next;
            out_idx_reg <= out_idx_next;
            out_re_reg  <= out_re_next;
            out_im_reg  <= out_im_next;
        end
    end

    // Working array holds no reset so it maps onto plain fabric registers.
    always_ff @(posedge CLK) begin
        ar_reg <= ar_next;
        ai_reg <= ai_next;
    end

    assign in_ready  = (state_reg == LOAD);
    assign busy      = (state_reg != LOAD);
    assign out_valid = (state_reg == OUT);
    assign out_last  = out_valid && (out_idx_reg == 3'd7);
    assign out_index = out_idx_reg;
    assign out_real  = out_re_reg;
    assign out_imag  = out_im_reg;

endmodule

// File: tb/tb_ifft8_stream.sv
// Scoreboard bench for ifft8_stream: directed test-plan frames plus random frames
// checked against a behavioural reference of the inverse FFT arithmetic.
module tb_ifft8_stream;
    typedef int arr8_t [8];
    typedef struct { int re; int im; int idx; } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_real = '0;
    logic [15:0] in_imag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_real;
    logic [15:0] out_imag;
    logic [2:0]  out_index;
    logic        out_last;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    ifft8_stream #(.DATA_W(16), .TW_COEF(181)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag),
        .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint w19(input longint v);
        longint t;
        t = v & 64'h7FFFF;
        if (t >= 64'h40000) t = t - 64'h80000;
        return t;
    endfunction

    // Reference: the decimation-in-time inverse FFT written as plain integer math.
    function automatic void ref_ifft(input arr8_t xr, input arr8_t xi,
                                     output arr8_t yr, output arr8_t yi);
        longint gr[8], gim[8], hr[8], him[8], vr[8], vi[8];
        longint t0, t1, t2, t3;
        int pa[4] = '{0, 2, 1, 3};
        for (int j = 0; j < 4; j++) begin
            gr[2*j]    = w19(longint'(xr[pa[j]]) + xr[pa[j]+4]);
            gim[2*j]   = w19(longint'(xi[pa[j]]) + xi[pa[j]+4]);
            gr[2*j+1]  = w19(longint'(xr[pa[j]]) - xr[pa[j]+4]);
            gim[2*j+1] = w19(longint'(xi[pa[j]]) - xi[pa[j]+4]);
        end
        for (int b = 0; b < 8; b += 4) begin
            hr[b]    = w19(gr[b] + gr[b+2]);       him[b]   = w19(gim[b] + gim[b+2]);
            hr[b+2]  = w19(gr[b] - gr[b+2]);       him[b+2] = w19(gim[b] - gim[b+2]);
            hr[b+1]  = w19(gr[b+1] - gim[b+3]);    him[b+1] = w19(gim[b+1] + gr[b+3]);
            hr[b+3]  = w19(gr[b+1] + gim[b+3]);    him[b+3] = w19(gim[b+1] - gr[b+3]);
        end
        t0 = w19(hr[5] - him[5]);
        t1 = w19(hr[5] + him[5]);
        t2 = w19(-hr[7] - him[7]);
        t3 = w19(hr[7] - him[7]);
        hr[5] = w19((t0 * 181) >>> 8);  him[5] = w19((t1 * 181) >>> 8);
        hr[7] = w19((t2 * 181) >>> 8);  him[7] = w19((t3 * 181) >>> 8);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                vr[k] = hr[k] - him[k+4];  vi[k] = him[k] + hr[k+4];
                vr[k+4] = hr[k] + him[k+4];  vi[k+4] = him[k] - hr[k+4];
            end else begin
                vr[k] = hr[k] + hr[k+4];  vi[k] = him[k] + him[k+4];
                vr[k+4] = hr[k] - hr[k+4];  vi[k+4] = him[k] - him[k+4];
            end
        end
        for (int k = 0; k < 8; k++) begin
            yr[k] = int'(w19(vr[k]) >>> 3);
            yi[k] = int'(w19(vi[k]) >>> 3);
        end
    endfunction

    task automatic push_frame(input arr8_t yr, input arr8_t yi);
        exp_t e;
        for (int n = 0; n < 8; n++) begin
            e.re = yr[n];  e.im = yi[n];  e.idx = n;
            sb.push_back(e);
        end
    endtask

    task automatic push_const(input int re, input int im);
        arr8_t yr, yi;
        for (int n = 0; n < 8; n++) begin yr[n] = re; yi[n] = im; end
        push_frame(yr, yi);
    endtask

    // Drives 8 bins; optional gaps, junk during compute, and latency checks.
    task automatic send_frame(input arr8_t re, input arr8_t im,
                              input bit gaps, input bit junk, input bit do_lat);
        int w;
        for (int k = 0; k < 8; k++) begin
            if (gaps && (k % 2 == 1)) begin
                in_valid = 1'b0;
                @(posedge CLK); #1;
            end
            in_valid = 1'b1;
            in_real  = 16'(re[k]);
            in_imag  = 16'(im[k]);
            w = 0;
            while (!in_ready && w < 3000) begin @(posedge CLK); #1; w++; end
            if (w >= 3000) chk("in_ready_timeout", in_ready, 1);
            @(posedge CLK); #1;
        end
        if (junk) begin
            in_real = 16'($urandom_range(0, 65535));
            in_imag = 16'($urandom_range(0, 65535));
        end else begin
            in_valid = 1'b0;
        end
        if (do_lat) begin
            for (int e = 1; e <= 5; e++) begin
                @(posedge CLK); #1;
                if (e == 2) chk("in_ready_compute", in_ready, 0);
                if (e == 4) chk("latency_early", out_valid, 0);
                if (e == 5) chk("latency", out_valid, 1);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 3000) begin
            @(posedge CLK); #1; n++;
        end
        if (n >= 3000) chk("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge CLK) begin
        if (!RST && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got n=%0d expected no output", out_index);
            end else begin
                mon_e = sb.pop_front();
                $display("OUT n=%0d re=%0d im=%0d last=%0d", out_index,
                         $signed(out_real), $signed(out_imag), out_last);
                chk("out_real", $signed(out_real), mon_e.re);
                chk("out_imag", $signed(out_imag), mon_e.im);
                chk("out_index", out_index, mon_e.idx);
                chk("out_last", out_last, (mon_e.idx == 7) ? 1 : 0);
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK); #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        arr8_t zr, zi, imp, tone, r, i, yr, yi;
        arr8_t tone_r = '{256, 181, 0, -181, -256, -181, 0, 181};
        arr8_t tone_i = '{0, 181, 256, 181, 0, -181, -256, -181};
        logic [15:0] held_r, held_i;
        int n;

        for (int k = 0; k < 8; k++) begin zr[k] = 0; zi[k] = 0; end
        imp = zr;  imp[0] = 2048;
        tone = zr; tone[1] = 2048;

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_real", out_real, 0);
        RST = 1'b0;
        @(posedge CLK); #1;

        push_const(256, 0);
        send_frame(imp, zi, 0, 0, 1);
        wait_done();

        push_frame(tone_r, tone_i);
        send_frame(tone, zi, 0, 0, 1);
        wait_done();

        r = zr; r[0] = -1;
        push_const(-1, 0);
        send_frame(r, zi, 0, 0, 1);
        wait_done();
        r[0] = 7;
        push_const(0, 0);
        send_frame(r, zi, 0, 0, 1);
        wait_done();

        push_const(256, 0);
        send_frame(imp, zi, 1, 1, 1);
        wait_done();

        // Backpressure at n=2 on a tone frame.
        push_frame(tone_r, tone_i);
        send_frame(tone, zi, 0, 0, 1);
        n = 0;
        while (!(out_valid && out_index == 3'd2) && n < 100) begin @(posedge CLK); #1; n++; end
        chk("bp_reach_n2", out_index, 2);
        out_ready = 1'b0;
        held_r = out_real;
        held_i = out_imag;
        repeat (3) begin
            @(posedge CLK); #1;
            chk("bp_index_hold", out_index, 2);
            chk("bp_real_hold", out_real, held_r);
            chk("bp_imag_hold", out_imag, held_i);
            chk("bp_valid_hold", out_valid, 1);
        end
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && out_last) && n < 100) begin @(posedge CLK); #1; n++; end
        chk("bp_in_ready_before_last", in_ready, 0);
        @(posedge CLK); #1;
        chk("bp_in_ready_after", in_ready, 1);
        chk("bp_valid_after", out_valid, 0);
        chk("bp_index_after", out_index, 0);

        // Async reset while the frame sits in ST3; this frame is discarded.
        send_frame(imp, zi, 0, 0, 0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("mid_busy", busy, 1);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_real", out_real, 0);
        chk("mid_rst_out_imag", out_imag, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        push_const(256, 0);
        send_frame(imp, zi, 0, 0, 1);
        wait_done();

        // Random frames with random output backpressure.
        rand_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < 8; k++) begin
                if (f % 2 == 0) begin
                    r[k] = $urandom_range(0, 4095) - 2048;
                    i[k] = $urandom_range(0, 4095) - 2048;
                end else begin
                    r[k] = $urandom_range(0, 65535) - 32768;
                    i[k] = $urandom_range(0, 65535) - 32768;
                end
            end
            ref_ifft(r, i, yr, yi);
            push_frame(yr, yi);
            send_frame(r, i, f % 3 == 1, f % 4 == 2, 1);
            wait_done();
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(posedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
